fabric_cfg_loader: RTL and testbench
====================================

# fabric_cfg_loader

Parametrised configuration loader for the island-style fabric. It accepts a word-wide bitstream over a valid/ready handshake and serialises it LSB-first into the fabric's two scan chains: first the connection chain (SBs, CBs, tile muxes), then the CLB chain. It can optionally read back both chains by rotating them in place and checking a CRC-16, then releases the user-clock enable. It sits between the host/boot interface and `fpga_top`-class fabrics of any `FPGA_WIDTH`. Chain lengths are parameters, so one loader serves every fabric size.

## Interface
Parameters:
- `CONN_CHAIN_LEN`, 64: connection scan-chain length in bits; must be ≥1.
- `CLB_CHAIN_LEN`, 32: CLB scan-chain length in bits; must be ≥1.
- `WORD_WIDTH`, 8: bitstream word width; must be ≥2.

Ports:
- `clk`  in  1  single clock for the loader; the fabric `scan_clk` is `clk` gated by the per-chain clock enables.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin loading; ignored while `busy`.
- `verify_en`  in  1  sampled with `start`; 1 runs readback verification.
- `cfg_data`  in  WORD_WIDTH  bitstream word, LSB shifted first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  loader accepts a word this cycle.
- `conn_scan_in`, `clb_scan_in`  out  1  serial data into each chain.
- `conn_scan_en`, `clb_scan_en`  out  1  scan-mode select for each chain.
- `conn_scan_clk_en`, `clb_scan_clk_en`  out  1  chain shifts on this `clk` edge.
- `conn_scan_out`, `clb_scan_out`  in  1  chain tail, combinational from the last flop.
- `busy`, `done`, `error`  out  1  status.
- `fabric_en`  out  1  user-clock enable; 1 only when the fabric is configured.

## Operation
- Total bits T = CONN_CHAIN_LEN + CLB_CHAIN_LEN. Words to load = ceil(T/WORD_WIDTH). Unused high bits of the last word are discarded.
- States: IDLE, FETCH, SHIFT, VFY_CONN, VFY_CLB, CHECK, DONE, ERR.
- IDLE/DONE/ERR + `start` → FETCH. This clears the CRC and bit counter, clears `done`/`error`, drops `fabric_en`, and latches `verify_en`.
- FETCH: `cfg_ready`=1. On `cfg_valid`&`cfg_ready`, latch the word into the shift register and go to SHIFT.
- SHIFT: one bit per cycle.
  - While bit index < CONN_CHAIN_LEN, the bit drives `conn_scan_in` with `conn_scan_clk_en`=1.
  - Otherwise the bit drives `clb_scan_in` with `clb_scan_clk_en`=1.
  - Each shifted bit also updates the CRC.
  - The word ends after WORD_WIDTH bits or at bit T, whichever is first.
  - Word end with bits remaining → FETCH. After bit T → VFY_CONN if verification is latched, else DONE.
- `conn_scan_en`=1 from FETCH through VFY_CONN. `clb_scan_en`=1 from FETCH through VFY_CLB. Both are 0 elsewhere.
- VFY_CONN: CONN_CHAIN_LEN cycles.
  - `conn_scan_in`=`conn_scan_out` and `conn_scan_clk_en`=1, so the chain rotates back to its loaded content.
  - `conn_scan_out` feeds a second CRC.
- VFY_CLB: same rotation on the CLB chain for CLB_CHAIN_LEN cycles → CHECK.
- CHECK: one cycle. CRCs equal → DONE, else ERR.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, one bit per shift, no final XOR.
- DONE: `done`=1, `fabric_en`=1. ERR: `error`=1, `fabric_en`=0.
- `busy`=1 in FETCH, SHIFT, VFY_*, CHECK.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, CRCs 0xFFFF, counters 0.
- Reset mid-load: outputs immediately 0 and `fabric_en`=0. Chain contents are undefined; a new `start` is required.
- `start`→FETCH in 1 cycle. Handshake cycle → first shift edge on the next cycle.
- No shifting occurs in FETCH. `cfg_valid` low stalls with all clock enables at 0.
- Load cycles with `cfg_valid` held high: T + words.
- Verify adds T + 1 cycles. `done`/`error` rise the cycle after CHECK.
- `start` while `busy` is ignored.
- `start` in the same cycle as the last shift is ignored.
- At most one of `conn_scan_clk_en`/`clb_scan_clk_en` is 1 in any cycle.
- `cfg_data` is sampled only on the handshake cycle.
- Counter widths are sized to $clog2(T+1) and $clog2(WORD_WIDTH+1). They must not wrap for any legal parameter set.

## Test plan
- CONN=12, CLB=10, W=8, no verify, words 0xA5, 0x3C, 0x1F with valid held high:
  - conn chain model holds bits 0..11 of the stream and clb chain holds bits 12..21;
  - `done`=1 and `fabric_en`=1 exactly 25 cycles after FETCH entry;
  - bits 6..7 of 0x1F are never shifted.
- Same stream with verify and a behavioural chain model → chains unchanged after rotation, `done`=1 at 25+23 cycles, `error`=0.
- Chain model with one bit flipped during VFY_CLB → ERR, `error`=1, `fabric_en`=0. A following `start` restarts, and a clean load reaches DONE.
- `cfg_valid` toggled 1/0 every cycle → no scan clock enable ever asserts in FETCH, and final chain contents match the first test.
- `rst_n` pulled low on the 7th SHIFT cycle → all outputs 0 in the same cycle, state IDLE.
- `start` pulsed while `busy` → ignored, and the load completes unchanged. CONN=1, CLB=1, W=2 → one word, both chains loaded, `done` after 3 cycles.

Source files
------------

// File: rtl/fabric_cfg_loader.sv
// Configuration loader for the island-style fabric.
// Takes a word-wide bitstream over valid/ready, shifts it LSB-first into the
// connection chain and then the CLB chain, and can optionally rotate both
// chains in place to compare a readback CRC-16 against the load CRC.
module fabric_cfg_loader #(
    parameter int CONN_CHAIN_LEN = 64,
    parameter int CLB_CHAIN_LEN  = 32,
    parameter int WORD_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  conn_scan_in,
    output logic                  clb_scan_in,
    output logic                  conn_scan_en,
    output logic                  clb_scan_en,
    output logic                  conn_scan_clk_en,
    output logic                  clb_scan_clk_en,
    input  logic                  conn_scan_out,
    input  logic                  clb_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  fabric_en
);

    localparam int TOTAL_BITS = CONN_CHAIN_LEN + CLB_CHAIN_LEN;
    localparam int BIT_CNT_W  = $clog2(TOTAL_BITS + 1);
    localparam int WORD_CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [BIT_CNT_W-1:0]  CONN_LEN_C = BIT_CNT_W'(CONN_CHAIN_LEN);
    localparam logic [BIT_CNT_W-1:0]  CONN_LAST  = BIT_CNT_W'(CONN_CHAIN_LEN - 1);
    localparam logic [BIT_CNT_W-1:0]  CLB_LAST   = BIT_CNT_W'(CLB_CHAIN_LEN - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = BIT_CNT_W'(TOTAL_BITS - 1);
    localparam logic [WORD_CNT_W-1:0] WORD_LAST  = WORD_CNT_W'(WORD_WIDTH - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_VFY_CONN = 3'd3;
    localparam logic [2:0] S_VFY_CLB  = 3'd4;
    localparam logic [2:0] S_CHECK    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [2:0] S_ERR      = 3'd7;

    logic [2:0]            r_state;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [BIT_CNT_W-1:0]  r_bitCnt;
    logic [WORD_CNT_W-1:0] r_wordCnt;
    logic [15:0]           r_crcLoad;
    logic [15:0]           r_crcRead;
    logic                  r_verify;

    logic w_inConn;
    logic w_lastBit;
    logic w_lastOfWord;
    logic w_canStart;

    // One serial step of CRC-16-CCITT (poly 0x1021), MSB-first register.
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic din);
        crcStep = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
    endfunction

    assign w_inConn     = (r_bitCnt < CONN_LEN_C);
    assign w_lastBit    = (r_bitCnt == LAST_BIT);
    assign w_lastOfWord = (r_wordCnt == WORD_LAST);
    assign w_canStart   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);

    // Sequencer: fetch words, shift them out bit by bit, then optionally rotate and compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_wordCnt <= '0;
            r_crcLoad <= 16'hFFFF;
            r_crcRead <= 16'hFFFF;
            r_verify  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_bitCnt  <= '0;
                        r_wordCnt <= '0;
                        r_crcLoad <= 16'hFFFF;
                        r_crcRead <= 16'hFFFF;
                        r_verify  <= verify_en;
                    end
                end
                S_FETCH: begin
                    if (cfg_valid) begin
                        r_shift   <= cfg_data;
                        r_wordCnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_crcLoad <= crcStep(r_crcLoad, r_shift[0]);
                    r_shift   <= r_shift >> 1;
                    r_wordCnt <= r_wordCnt + 1'b1;
                    r_bitCnt  <= r_bitCnt + 1'b1;
                    if (w_lastBit) begin
                        if (r_verify) begin
                            r_bitCnt <= '0;
                            r_state  <= S_VFY_CONN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else if (w_lastOfWord) begin
                        r_state <= S_FETCH;
                    end
                end
                S_VFY_CONN: begin
                    r_crcRead <= crcStep(r_crcRead, conn_scan_out);
                    r_bitCnt  <= r_bitCnt + 1'b1;
                    if (r_bitCnt == CONN_LAST) begin
                        r_bitCnt <= '0;
                        r_state  <= S_VFY_CLB;
                    end
                end
                S_VFY_CLB: begin
                    r_crcRead <= crcStep(r_crcRead, clb_scan_out);
                    r_bitCnt  <= r_bitCnt + 1'b1;
                    if (r_bitCnt == CLB_LAST) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_state <= (r_crcLoad == r_crcRead) ? S_DONE : S_ERR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from state only, so an async reset clears them immediately.
    always_comb begin
        cfg_ready        = 1'b0;
        conn_scan_in     = 1'b0;
        clb_scan_in      = 1'b0;
        conn_scan_clk_en = 1'b0;
        clb_scan_clk_en  = 1'b0;
        conn_scan_en     = 1'b0;
        clb_scan_en      = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        fabric_en        = 1'b0;
        case (r_state)
            S_FETCH: begin
                cfg_ready    = 1'b1;
                conn_scan_en = 1'b1;
                clb_scan_en  = 1'b1;
                busy         = 1'b1;
            end
            S_SHIFT: begin
                conn_scan_en = 1'b1;
                clb_scan_en  = 1'b1;
                busy         = 1'b1;
                if (w_inConn) begin
                    conn_scan_in     = r_shift[0];
                    conn_scan_clk_en = 1'b1;
                end else begin
                    clb_scan_in     = r_shift[0];
                    clb_scan_clk_en = 1'b1;
                end
            end
            S_VFY_CONN: begin
                conn_scan_en     = 1'b1;
                clb_scan_en      = 1'b1;
                busy             = 1'b1;
                conn_scan_in     = conn_scan_out;
                conn_scan_clk_en = 1'b1;
            end
            S_VFY_CLB: begin
                clb_scan_en     = 1'b1;
                busy            = 1'b1;
                clb_scan_in     = clb_scan_out;
                clb_scan_clk_en = 1'b1;
            end
            S_CHECK: busy = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                fabric_en = 1'b1;
            end
            S_ERR: error = 1'b1;
            default: ;
        endcase
    end

    logic w_unusedStart;
    assign w_unusedStart = w_canStart;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader with behavioural scan-chain models.
// Main instance: CONN=12, CLB=10, W=8; small instance: CONN=1, CLB=1, W=2.
module tb_fabric_cfg_loader;

   localparam int CONN  = 12;
   localparam int CLB   = 10;
   localparam int W     = 8;
   localparam int LIMIT = 200;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_n;
   logic start, verifyEn, cfgValid, cfgReady;
   logic [W-1:0] cfgData;
   logic connScanIn, clbScanIn, connScanEn, clbScanEn, connClkEn, clbClkEn;
   logic connScanOut, clbScanOut;
   logic busy, done, error, fabricEn;

   logic sStart, sVerifyEn, sValid, sReady;
   logic [1:0] sData;
   logic sConnIn, sClbIn, sConnEn, sClbEn, sConnClkEn, sClbClkEn;
   logic sBusy, sDone, sError, sFabricEn;

   int compared = 0;
   int mismatched = 0;

   // Behavioural chain models: position 0 is the tail, new bits enter at the top.
   logic [CONN-1:0] connChain;
   logic [CLB-1:0]  clbChain;
   int connShifts = 0;
   int clbShifts = 0;
   int connBase = 0;
   int clbBase = 0;
   logic corruptArm;
   logic sConnChain, sClbChain;
   int sConnShifts = 0;
   int sClbShifts = 0;

   logic [7:0] words [3];

   fabric_cfg_loader #(.CONN_CHAIN_LEN(CONN), .CLB_CHAIN_LEN(CLB), .WORD_WIDTH(W)) u_dut (
      .clk(clock), .rst_n(rst_n), .start(start), .verify_en(verifyEn),
      .cfg_data(cfgData), .cfg_valid(cfgValid), .cfg_ready(cfgReady),
      .conn_scan_in(connScanIn), .clb_scan_in(clbScanIn),
      .conn_scan_en(connScanEn), .clb_scan_en(clbScanEn),
      .conn_scan_clk_en(connClkEn), .clb_scan_clk_en(clbClkEn),
      .conn_scan_out(connScanOut), .clb_scan_out(clbScanOut),
      .busy(busy), .done(done), .error(error), .fabric_en(fabricEn)
   );

   fabric_cfg_loader #(.CONN_CHAIN_LEN(1), .CLB_CHAIN_LEN(1), .WORD_WIDTH(2)) u_small (
      .clk(clock), .rst_n(rst_n), .start(sStart), .verify_en(sVerifyEn),
      .cfg_data(sData), .cfg_valid(sValid), .cfg_ready(sReady),
      .conn_scan_in(sConnIn), .clb_scan_in(sClbIn),
      .conn_scan_en(sConnEn), .clb_scan_en(sClbEn),
      .conn_scan_clk_en(sConnClkEn), .clb_scan_clk_en(sClbClkEn),
      .conn_scan_out(sConnChain), .clb_scan_out(sClbChain),
      .busy(sBusy), .done(sDone), .error(sError), .fabric_en(sFabricEn)
   );

   // Connection chain of the main instance shifts on its clock enable.
   always @(posedge clock) begin
      if (connClkEn) begin
         connChain  <= {connScanIn, connChain[CONN-1:1]};
         connShifts <= connShifts + 1;
      end
   end

   // CLB chain of the main instance shifts on its clock enable.
   always @(posedge clock) begin
      if (clbClkEn) begin
         clbChain  <= {clbScanIn, clbChain[CLB-1:1]};
         clbShifts <= clbShifts + 1;
      end
   end

   // Single-flop chains of the small instance.
   always @(posedge clock) begin
      if (sConnClkEn) begin
         sConnChain  <= sConnIn;
         sConnShifts <= sConnShifts + 1;
      end
      if (sClbClkEn) begin
         sClbChain  <= sClbIn;
         sClbShifts <= sClbShifts + 1;
      end
   end

   assign connScanOut = connChain[0];
   // A corrupted tail on the third CLB readback shift models a flipped chain bit.
   assign clbScanOut  = clbChain[0] ^ (corruptArm && ((clbShifts - clbBase) == CLB + 2));

   function automatic logic [31:0] outVec();
      return {21'd0, cfgReady, connScanIn, clbScanIn, connScanEn, clbScanEn,
              connClkEn, clbClkEn, busy, done, error, fabricEn};
   endfunction

   function automatic logic [31:0] sOutVec();
      return {21'd0, sReady, sConnIn, sClbIn, sConnEn, sClbEn,
              sConnClkEn, sClbClkEn, sBusy, sDone, sError, sFabricEn};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Runs one load on the main instance; cyc counts edges after FETCH entry until done/error.
   task automatic applyStimulus(input logic vfy, input bit toggleValid, input int pokeAt,
                                output int cyc, output int enViol);
      int wordIdx;
      bit hs;
      wordIdx = 0;
      enViol = 0;
      connBase = connShifts;
      clbBase = clbShifts;
      @(negedge clock);
      start = 1'b1;
      verifyEn = vfy;
      cfgValid = 1'b0;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!(done || error) && cyc < LIMIT) begin
         start = (cyc == pokeAt);
         cfgValid = toggleValid ? ((cyc % 2) == 0) : 1'b1;
         cfgData = words[wordIdx];
         if (cfgReady && (connClkEn || clbClkEn)) enViol++;
         if (connClkEn && clbClkEn) enViol++;
         hs = cfgValid && cfgReady;
         @(negedge clock);
         cyc++;
         if (hs && wordIdx < 2) wordIdx++;
      end
      start = 1'b0;
      cfgValid = 1'b0;
      checkOutput("no_timeout", (cyc < LIMIT) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int cyc;
      int viol;
      int seen;
      bit hs;
      int wIdx;
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      words[2] = 8'h1F;
      rst_n = 1'b0;
      start = 1'b0; verifyEn = 1'b0; cfgValid = 1'b0; cfgData = '0; corruptArm = 1'b0;
      sStart = 1'b0; sVerifyEn = 1'b0; sValid = 1'b0; sData = '0;
      #12;
      checkOutput("reset_outputs", outVec(), 32'd0);
      checkOutput("reset_small_outputs", sOutVec(), 32'd0);
      @(negedge clock);
      rst_n = 1'b1;

      $display("[TB] plain load");
      applyStimulus(1'b0, 1'b0, -1, cyc, viol);
      checkOutput("load_cycles", cyc, 32'd25);
      checkOutput("load_done_fen_err", {done, fabricEn, error}, 3'b110);
      checkOutput("load_conn_chain", connChain, 12'hCA5);
      checkOutput("load_clb_chain", clbChain, 10'h1F3);
      checkOutput("load_conn_shifts", connShifts - connBase, 32'd12);
      checkOutput("load_clb_shifts", clbShifts - clbBase, 32'd10);
      checkOutput("load_en_rules", viol, 32'd0);

      $display("[TB] load with verify");
      applyStimulus(1'b1, 1'b0, -1, cyc, viol);
      checkOutput("vfy_cycles", cyc, 32'd48);
      checkOutput("vfy_done_fen_err", {done, fabricEn, error}, 3'b110);
      checkOutput("vfy_conn_chain", connChain, 12'hCA5);
      checkOutput("vfy_clb_chain", clbChain, 10'h1F3);
      checkOutput("vfy_conn_shifts", connShifts - connBase, 32'd24);
      checkOutput("vfy_clb_shifts", clbShifts - clbBase, 32'd20);
      checkOutput("vfy_en_rules", viol, 32'd0);

      $display("[TB] verify with corrupted readback");
      corruptArm = 1'b1;
      applyStimulus(1'b1, 1'b0, -1, cyc, viol);
      corruptArm = 1'b0;
      checkOutput("err_cycles", cyc, 32'd48);
      checkOutput("err_done_fen_err", {done, fabricEn, error}, 3'b001);
      applyStimulus(1'b1, 1'b0, -1, cyc, viol);
      checkOutput("recover_cycles", cyc, 32'd48);
      checkOutput("recover_done_fen_err", {done, fabricEn, error}, 3'b110);

      $display("[TB] toggling valid");
      applyStimulus(1'b0, 1'b1, -1, cyc, viol);
      checkOutput("toggle_en_rules", viol, 32'd0);
      checkOutput("toggle_done", done, 1'b1);
      checkOutput("toggle_conn_chain", connChain, 12'hCA5);
      checkOutput("toggle_clb_chain", clbChain, 10'h1F3);

      $display("[TB] start while busy");
      applyStimulus(1'b0, 1'b0, 10, cyc, viol);
      checkOutput("busy_start_cycles", cyc, 32'd25);
      checkOutput("busy_start_conn", connChain, 12'hCA5);
      checkOutput("busy_start_clb", clbChain, 10'h1F3);
      applyStimulus(1'b0, 1'b0, 24, cyc, viol);
      checkOutput("last_shift_start_cycles", cyc, 32'd25);
      @(negedge clock);
      @(negedge clock);
      checkOutput("last_shift_start_stays_done", {done, busy}, 2'b10);

      $display("[TB] reset during shift");
      @(negedge clock);
      start = 1'b1;
      verifyEn = 1'b0;
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      wIdx = 0;
      cyc = 0;
      while (cyc < LIMIT) begin
         cfgValid = 1'b1;
         cfgData = words[wIdx];
         if (connClkEn || clbClkEn) seen++;
         if (seen == 7) break;
         hs = cfgValid && cfgReady;
         @(negedge clock);
         cyc++;
         if (hs && wIdx < 2) wIdx++;
      end
      checkOutput("rst_reached_7th_shift", seen, 32'd7);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_outputs", outVec(), 32'd0);
      cfgValid = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      checkOutput("rst_mid_idle", outVec(), 32'd0);

      $display("[TB] minimal parameter set");
      sConnBaseCheck();
      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Minimal instance: one 2-bit word fills both single-bit chains.
   task automatic sConnBaseCheck();
      int cyc;
      int cBase;
      int lBase;
      cBase = sConnShifts;
      lBase = sClbShifts;
      @(negedge clock);
      sStart = 1'b1;
      sVerifyEn = 1'b0;
      sValid = 1'b1;
      sData = 2'b10;
      @(negedge clock);
      sStart = 1'b0;
      cyc = 0;
      while (!sDone && cyc < LIMIT) begin
         @(negedge clock);
         cyc++;
      end
      sValid = 1'b0;
      checkOutput("small_cycles", cyc, 32'd3);
      checkOutput("small_chains", {sConnChain, sClbChain}, 2'b01);
      checkOutput("small_shifts", {sConnShifts - cBase, sClbShifts - lBase}, {32'd1, 32'd1});
      checkOutput("small_status", {sDone, sFabricEn, sError, sBusy}, 4'b1100);
   endtask

endmodule
